// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared system-bus constants and arbiter state type.
package sysbus_pkg;
    localparam int   TAG_WR_BIT = 12;
    localparam logic TAG_WR_VAL = 1'b0;
    localparam int   BEATS      = 8;
    typedef enum logic [1:0] {IDLE, ADDR, RDATA, WDATA} state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the port that did not win last goes first.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);
    always_comb gnt_o = (&req_i) ? (last_i ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the DRAM system bus between the I-cache (port 0) and D-cache (port 1),
// re-arbitrating only between whole line transactions.
module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = sysbus_pkg::BEATS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      c0_reqcyc,
    output logic                      c0_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] c0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
    output logic                      c0_respcyc,
    input  logic                      c0_respack,
    output logic [BUS_DATA_WIDTH-1:0] c0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,
    input  logic                      c1_reqcyc,
    output logic                      c1_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] c1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
    output logic                      c1_respcyc,
    input  logic                      c1_respack,
    output logic [BUS_DATA_WIDTH-1:0] c1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,
    output logic                      m_reqcyc,
    input  logic                      m_reqack,
    output logic [BUS_DATA_WIDTH-1:0] m_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_reqtag,
    input  logic                      m_respcyc,
    output logic                      m_respack,
    input  logic [BUS_DATA_WIDTH-1:0] m_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_resptag,
    output logic [1:0]                grant,
    output logic                      busy
);
    import sysbus_pkg::*;

    localparam int CW = $clog2(BEATS);

    state_e                      state_q, state_d;
    logic                        owner_q, owner_d;
    logic                        wr_q, wr_d;
    logic                        last_q, last_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [1:0]                  pick;
    logic                        own_reqcyc, own_respack, last_beat, fwd_req, fwd_resp;
    logic [BUS_DATA_WIDTH-1:0]   own_req;
    logic [BUS_TAG_WIDTH-1:0]    own_reqtag, pick_tag;

    rr_arb2 u_arb (
        .req_i  ({c1_reqcyc, c0_reqcyc}),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    assign own_reqcyc  = owner_q ? c1_reqcyc  : c0_reqcyc;
    assign own_req     = owner_q ? c1_req     : c0_req;
    assign own_reqtag  = owner_q ? c1_reqtag  : c0_reqtag;
    assign own_respack = owner_q ? c1_respack : c0_respack;
    assign pick_tag    = pick[1] ? c1_reqtag  : c0_reqtag;
    assign last_beat   = cnt_q == CW'(BEATS - 1);
    assign fwd_req     = state_q == ADDR || state_q == WDATA;
    assign fwd_resp    = state_q == RDATA;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (|pick) begin
                state_d = ADDR;
                owner_d = pick[1];
                last_d  = pick[1];
                wr_d    = pick_tag[TAG_WR_BIT] == TAG_WR_VAL;
            end
            ADDR: if (!own_reqcyc) state_d = IDLE;
                else if (m_reqack) begin
                    cnt_d   = '0;
                    state_d = wr_q ? WDATA : RDATA;
                end
            RDATA: if (m_respcyc && own_respack) begin
                cnt_d   = last_beat ? '0 : cnt_q + CW'(1);
                state_d = last_beat ? IDLE : RDATA;
            end
            WDATA: if (own_reqcyc && m_reqack) begin
                cnt_d   = last_beat ? '0 : cnt_q + CW'(1);
                state_d = last_beat ? IDLE : WDATA;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response routing follows the latched owner only; m_resptag is passed through untouched.
    always_comb begin
        m_reqcyc   = fwd_req && own_reqcyc;
        m_req      = fwd_req ? own_req : '0;
        m_reqtag   = state_q == ADDR ? own_reqtag : '0;
        m_respack  = fwd_resp && own_respack;
        c0_reqack  = fwd_req && !owner_q && m_reqack;
        c1_reqack  = fwd_req && owner_q && m_reqack;
        c0_respcyc = fwd_resp && !owner_q && m_respcyc;
        c1_respcyc = fwd_resp && owner_q && m_respcyc;
        c0_resp    = (fwd_resp && !owner_q) ? m_resp : '0;
        c1_resp    = (fwd_resp && owner_q) ? m_resp : '0;
        c0_resptag = (fwd_resp && !owner_q) ? m_resptag : '0;
        c1_resptag = (fwd_resp && owner_q) ? m_resptag : '0;
        grant      = state_q == IDLE ? 2'b00 : {owner_q, !owner_q};
        busy       = state_q != IDLE;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table for back-to-back fairness plus scoreboarded read/write
// transactions, contention, reset-abort and address-phase-abort sequences.
module tb_mem_bus_arbiter;
    import sysbus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        c0_reqcyc, c0_reqack, c0_respcyc, c0_respack;
    logic [63:0] c0_req, c0_resp;
    logic [12:0] c0_reqtag, c0_resptag;
    logic        c1_reqcyc, c1_reqack, c1_respcyc, c1_respack;
    logic [63:0] c1_req, c1_resp;
    logic [12:0] c1_reqtag, c1_resptag;
    logic        m_reqcyc, m_reqack, m_respcyc, m_respack;
    logic [63:0] m_req, m_resp;
    logic [12:0] m_reqtag, m_resptag;
    logic [1:0]  grant;
    logic        busy;

    int checks = 0;
    int failures = 0;
    bit sb_on = 1'b0;
    logic [64:0] rq[$];
    logic [63:0] wq[$];

    typedef struct {
        logic        c0r, c1r, ack;
        logic [1:0]  g;
        logic        bsy, mrc;
        logic [63:0] mreq;
    } vec_t;
    vec_t vt[40];

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .c0_reqcyc(c0_reqcyc), .c0_reqack(c0_reqack), .c0_req(c0_req), .c0_reqtag(c0_reqtag),
        .c0_respcyc(c0_respcyc), .c0_respack(c0_respack), .c0_resp(c0_resp), .c0_resptag(c0_resptag),
        .c1_reqcyc(c1_reqcyc), .c1_reqack(c1_reqack), .c1_req(c1_req), .c1_reqtag(c1_reqtag),
        .c1_respcyc(c1_respcyc), .c1_respack(c1_respack), .c1_resp(c1_resp), .c1_resptag(c1_resptag),
        .m_reqcyc(m_reqcyc), .m_reqack(m_reqack), .m_req(m_req), .m_reqtag(m_reqtag),
        .m_respcyc(m_respcyc), .m_respack(m_respack), .m_resp(m_resp), .m_resptag(m_resptag),
        .grant(grant), .busy(busy)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input logic v, input logic [63:0] d, input logic [12:0] t);
        if (p) begin
            c1_reqcyc = v; c1_req = d; c1_reqtag = t;
        end else begin
            c0_reqcyc = v; c0_req = d; c0_reqtag = t;
        end
    endtask

    task automatic pop_r(input bit p, input logic [63:0] d);
        logic [64:0] e;
        if (rq.size() == 0) begin
            checks++; failures++;
            $display("FAIL resp_unexpected: port %0d got %h, nothing expected", p, d);
        end else begin
            e = rq.pop_front();
            chk("resp_port", 64'(p), 64'(e[64]));
            chk("resp_data", d, e[63:0]);
        end
    endtask

    always @(negedge clk) begin
        if (sb_on && !reset) begin
            if (c0_respcyc && c0_respack) pop_r(1'b0, c0_resp);
            if (c1_respcyc && c1_respack) pop_r(1'b1, c1_resp);
            if (m_reqcyc && m_reqack) begin
                if (wq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL req_unexpected: m_req %h handshake, nothing expected", m_req);
                end else chk("m_req", m_req, wq.pop_front());
            end
        end
    end

    task automatic idle_chk(input string n);
        @(negedge clk);
        chk({n, "_busy"}, 64'(busy), 0);
        chk({n, "_grant"}, 64'(grant), 0);
        tick;
    endtask

    task automatic read_txn(input bit p, input logic [63:0] addr, input logic [7:0] base, input bit contend);
        logic [12:0] rt;
        set_req(p, 1'b1, addr, 13'h1000 | 13'(p));
        @(negedge clk);
        chk("rd_idle_grant", 64'(grant), 0);
        tick;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rd_addr_grant", 64'(grant), p ? 64'd2 : 64'd1);
            chk("rd_addr_mreq", m_req, addr);
            chk("rd_early_ack", 64'(p ? c1_reqack : c0_reqack), 0);
            tick;
        end
        m_reqack = 1'b1;
        wq.push_back(addr);
        @(negedge clk);
        chk("rd_addr_tag", 64'(m_reqtag), 64'(13'h1000 | 13'(p)));
        chk("rd_owner_ack", 64'(p ? c1_reqack : c0_reqack), 1);
        tick;
        set_req(p, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            if (contend && i == 3) set_req(1'b1, 1'b1, 64'h3000, 13'h0001);
            rt = 13'h1001 ^ 13'(i);
            m_respcyc = 1'b1; m_resp = {56'h0, base + 8'(i)}; m_resptag = rt;
            c0_respack = 1'b1; c1_respack = 1'b1;
            rq.push_back({p, m_resp});
            @(negedge clk);
            chk("rd_other_respcyc", 64'(p ? c0_respcyc : c1_respcyc), 0);
            chk("rd_m_respack", 64'(m_respack), 1);
            chk("rd_resptag", 64'(p ? c1_resptag : c0_resptag), 64'(rt));
            if (contend) chk("contend_c1_reqack", 64'(c1_reqack), 0);
            tick;
        end
        m_respcyc = 1'b0; m_resp = '0; m_resptag = '0; m_reqack = 1'b0;
        c0_respack = 1'b0; c1_respack = 1'b0;
    endtask

    task automatic write_txn(input bit p, input logic [63:0] addr, input logic [7:0] base, input int rst_at);
        logic [63:0] d;
        set_req(p, 1'b1, addr, 13'(p));
        @(negedge clk);
        chk("wr_idle_grant", 64'(grant), 0);
        chk("wr_idle_busy", 64'(busy), 0);
        tick;
        m_reqack = 1'b1;
        wq.push_back(addr);
        @(negedge clk);
        chk("wr_addr_grant", 64'(grant), p ? 64'd2 : 64'd1);
        chk("wr_addr_tag", 64'(m_reqtag), 64'(p));
        tick;
        for (int i = 0; i < 8; i++) begin
            d = {56'h0, base + 8'(i)};
            set_req(p, 1'b1, d, 13'(p));
            if (i == rst_at) begin
                reset = 1'b1; m_reqack = 1'b0;
                tick;
                reset = 1'b0;
                set_req(p, 1'b0, '0, '0);
                @(negedge clk);
                chk("rst_state", 64'(dut.state_q), 64'(IDLE));
                chk("rst_cnt", 64'(dut.cnt_q), 0);
                chk("rst_grant", 64'(grant), 0);
                chk("rst_m_reqcyc", 64'(m_reqcyc), 0);
                chk("rst_busy", 64'(busy), 0);
                tick;
                return;
            end
            wq.push_back(d);
            @(negedge clk);
            chk("wr_beat_grant", 64'(grant), p ? 64'd2 : 64'd1);
            chk("wr_beat_busy", 64'(busy), 1);
            tick;
        end
        m_reqack = 1'b0;
        set_req(p, 1'b0, '0, '0);
    endtask

    initial begin
        reset = 1'b1;
        set_req(1'b0, 1'b1, 64'h55, 13'h1000);
        set_req(1'b1, 1'b1, 64'h66, 13'h1000);
        m_reqack = 1'b1; m_respcyc = 1'b1; m_resp = '1; m_resptag = '1;
        c0_respack = 1'b1; c1_respack = 1'b1;
        tick; tick;
        @(negedge clk);
        chk("rst_out_grant", 64'(grant), 0);
        chk("rst_out_busy", 64'(busy), 0);
        chk("rst_out_m_reqcyc", 64'(m_reqcyc), 0);
        chk("rst_out_m_req", m_req, 0);
        chk("rst_out_m_respack", 64'(m_respack), 0);
        chk("rst_out_reqack", 64'({c1_reqack, c0_reqack}), 0);
        chk("rst_out_respcyc", 64'({c1_respcyc, c0_respcyc}), 0);
        chk("rst_out_resp", c0_resp | c1_resp, 0);
        tick;
        reset = 1'b0;
        set_req(1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0);
        m_reqack = 1'b0; c1_respack = 1'b0;
        @(negedge clk);
        chk("idle_m_respack", 64'(m_respack), 0);
        chk("idle_respcyc", 64'({c1_respcyc, c0_respcyc}), 0);
        tick;
        m_respcyc = 1'b0; m_resp = '0; m_resptag = '0; c0_respack = 1'b0;
        sb_on = 1'b1;

        read_txn(1'b0, 64'h1000, 8'hA0, 1'b0);
        write_txn(1'b1, 64'h2040, 8'hB0, 8);
        idle_chk("wr_end");

        // Both ports hold write requests continuously with memory always ready.
        for (int t = 0; t < 4; t++) begin
            vt[t*10] = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 64'h0};
            for (int k = 1; k < 10; k++)
                vt[t*10+k] = '{1'b1, 1'b1, 1'b1, (t % 2 == 1) ? 2'b10 : 2'b01, 1'b1, 1'b1,
                               (t % 2 == 1) ? 64'hC1 : 64'hC0};
        end
        sb_on = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int r = 0; r < 40; r++) begin
            set_req(1'b0, vt[r].c0r, 64'hC0, 13'h0000);
            set_req(1'b1, vt[r].c1r, 64'hC1, 13'h0001);
            m_reqack = vt[r].ack;
            @(negedge clk);
            chk($sformatf("vec%0d_grant", r), 64'(grant), 64'(vt[r].g));
            chk($sformatf("vec%0d_busy", r), 64'(busy), 64'(vt[r].bsy));
            chk($sformatf("vec%0d_m_reqcyc", r), 64'(m_reqcyc), 64'(vt[r].mrc));
            chk($sformatf("vec%0d_m_req", r), m_req, vt[r].mreq);
            tick;
        end
        set_req(1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0);
        m_reqack = 1'b0;
        idle_chk("vec_end");
        sb_on = 1'b1;

        read_txn(1'b0, 64'h1100, 8'hC0, 1'b1);
        write_txn(1'b1, 64'h3000, 8'hE0, 8);
        idle_chk("contend_end");

        write_txn(1'b0, 64'h6000, 8'hF0, 4);
        read_txn(1'b0, 64'h7000, 8'h70, 1'b0);
        idle_chk("post_rst_end");

        set_req(1'b0, 1'b1, 64'h4000, 13'h1000);
        @(negedge clk);
        chk("abort_idle_grant", 64'(grant), 0);
        tick;
        set_req(1'b1, 1'b1, 64'h5000, 13'h0001);
        @(negedge clk);
        chk("abort_addr_grant", 64'(grant), 1);
        chk("abort_c1_reqack", 64'(c1_reqack), 0);
        tick;
        set_req(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("abort_m_reqcyc", 64'(m_reqcyc), 0);
        tick;
        write_txn(1'b1, 64'h5000, 8'hD0, 8);
        idle_chk("abort_end");

        chk("rq_drained", 64'(rq.size()), 0);
        chk("wq_drained", 64'(wq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single DRAM-side system bus between two cache clients: port 0 (instruction cache) and port 1 (data cache).
- Arbitrates only at transaction boundaries with round-robin priority and holds the grant for a whole transaction:
  - read: address phase plus 8 response beats;
  - write: address phase plus 8 data beats.
- Sits between the two cache instances and the top-level m_bus.

Parameters:
- BUS_DATA_WIDTH, 64, width of address/data on all bus channels.
- BUS_TAG_WIDTH, 13, width of request/response tags.
- BEATS, 8, 64-bit beats per 512-bit cache line.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- c0_reqcyc  in  1  port-0 request valid (address phase, then write data beats)
- c0_reqack  out  1  ack to port 0 (forwarded m_reqack while granted)
- c0_req  in  64  port-0 address, or write data during write beats
- c0_reqtag  in  13  port-0 tag; bit 12 == 0 means write, 1 means read
- c0_respcyc  out  1  response beat valid to port 0
- c0_respack  in  1  port-0 response ack
- c0_resp  out  64  response data to port 0
- c0_resptag  out  13  response tag to port 0
- c1_*  (same eight signals, same directions and widths)  port 1 (data cache)
- m_reqcyc  out  1  memory request valid
- m_reqack  in  1  memory request/beat ack
- m_req  out  64  memory address or write data
- m_reqtag  out  13  memory request tag
- m_respcyc  in  1  memory response beat valid
- m_respack  out  1  memory response ack
- m_resp  in  64  memory response data
- m_resptag  in  13  memory response tag
- grant  out  2  one-hot current owner; 00 when idle
- busy  out  1  high when any state other than IDLE

Behaviour:
- Reset values: state=IDLE, grant=00, last=1 (so port 0 wins the first tie), beat counter=0, busy=0.
  - All outputs to both ports and to memory are 0.
  - Reset mid-transaction aborts it immediately; no beats are replayed.
- State machine: IDLE, ADDR, RDATA, WDATA.
- IDLE:
  - m_reqcyc=0.
  - If exactly one cN_reqcyc is high, grant that port.
  - If both are high, grant the port not equal to last.
  - Go to ADDR, latching the owner, the write flag (reqtag[12]==0) and last=owner.
  - Arbitration latency: 1 cycle from reqcyc to the first forwarded m_reqcyc.
- ADDR:
  - Forward owner's reqcyc/req/reqtag to m_*; owner's reqack = m_reqack.
  - On m_reqcyc & m_reqack: cnt=0; go to WDATA if write, RDATA if read.
  - If the owner drops reqcyc before ack, return to IDLE and grant=00.
- RDATA:
  - Owner's respcyc/resp/resptag = m_*; m_respack = owner's respack.
  - Count beats where m_respcyc & m_respack.
  - On beat BEATS-1, go to IDLE.
  - Routing is by owner, never by m_resptag.
- WDATA:
  - Forward owner's reqcyc/req to m_*; owner's reqack = m_reqack.
  - Count beats where m_reqcyc & m_reqack.
  - On beat BEATS-1, go to IDLE.
- Non-owner port: reqack=0, respcyc=0, resp/resptag=0 at all times. Its pending reqcyc is held off, not lost.
- Datapath: all forwarding is combinational (no added latency). The counter is 3 bits ($clog2(BEATS)) and wraps to 0 on the transaction end.
- Back-to-back and fairness: returning to IDLE costs 1 cycle. A requester that was refused is granted next whenever the other port requests again, so neither port can starve.
- m_respcyc outside RDATA is ignored and m_respack stays 0.

Decomposition:
- Shared package sysbus_pkg holds:
  - tag write-bit index (12) and value (0);
  - BEATS;
  - state enum {IDLE, ADDR, RDATA, WDATA}.
- Sub-module rr_arb2 is natural: combinational 2-way round-robin pick from reqcyc pair and last, producing a one-hot grant. Everything else stays in mem_bus_arbiter.

Test Plan:
- Single read, port 0:
  - Stimulus: c0 reqcyc, addr 0x1000, tag[12]=1; memory acks after 2 cycles and returns 8 beats 0xA0..0xA7.
  - Required: grant=01; c0 sees 8 respcyc beats with data A0..A7; c1_respcyc stays 0; back to IDLE afterwards.
- Single write, port 1:
  - Stimulus: addr 0x2040, tag[12]=0; data beats 0xB0..0xB7.
  - Required: m_req shows 0x2040, then B0..B7, each ended by m_reqack; grant=10 throughout; busy drops after beat 8.
- Simultaneous requests after reset:
  - Required: port 0 is served first, then port 1 with exactly one IDLE cycle between.
  - Repeating with both held high continuously must alternate grants 01, 10, 01, 10.
- Mid-transaction contention:
  - Stimulus: c1 raises reqcyc during c0's RDATA beat 3.
  - Required: c1_reqack stays 0 until c0's 8th beat; c1 is granted on the next ADDR.
- Reset during WDATA beat 4:
  - Required: next cycle state=IDLE, grant=00, m_reqcyc=0, counter=0; a fresh c0 read then completes normally.
- Address-phase abort:
  - Stimulus: c0 drops reqcyc before m_reqack.
  - Required: arbiter returns to IDLE; a pending c1 request is granted next cycle.
